// File: rtl/midi_message_parser_if.sv
// Byte-in / event-out bundle between the MIDI UART receiver, the message
// parser and the voice allocator.
interface midi_message_parser_if;
    logic [7:0]  byteInput;
    logic        byteInputReady;
    logic        noteValid;
    logic        noteGate;
    logic [6:0]  noteNumber;
    logic [6:0]  noteVelocity;
    logic        ctrlValid;
    logic [6:0]  ctrlNumber;
    logic [6:0]  ctrlValue;
    logic        bendValid;
    logic [13:0] bendValue;
    logic [3:0]  eventChannel;

    // Parser side: consumes bytes, produces events.
    modport slave (
        input  byteInput, byteInputReady,
        output noteValid, noteGate, noteNumber, noteVelocity,
        output ctrlValid, ctrlNumber, ctrlValue,
        output bendValid, bendValue, eventChannel
    );

    // Receiver/consumer side.
    modport master (
        output byteInput, byteInputReady,
        input  noteValid, noteGate, noteNumber, noteVelocity,
        input  ctrlValid, ctrlNumber, ctrlValue,
        input  bendValid, bendValue, eventChannel
    );
endinterface

// File: rtl/midi_message_parser.sv
// MIDI channel-voice message parser: assembles note on/off, control change and
// pitch bend events from a byte stream, with running status. Realtime bytes are
// transparent; system common / SysEx bytes cancel running status.
module midi_message_parser #(
    parameter bit          CHANNEL_FILTER_EN = 1'b0,
    parameter int unsigned CHANNEL           = 0
) (
    input  logic                  i_clock,
    input  logic                  i_resetN,
    midi_message_parser_if.slave  bus
);
    localparam logic [3:0] ChannelNib = 4'(CHANNEL);

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_t;

    state_t      r_state;
    logic        r_ready_prev;
    logic [7:0]  r_status;
    logic        r_rs_valid;
    logic [6:0]  r_d1;

    logic        r_note_valid;
    logic        r_note_gate;
    logic [6:0]  r_note_number;
    logic [6:0]  r_note_velocity;
    logic        r_ctrl_valid;
    logic [6:0]  r_ctrl_number;
    logic [6:0]  r_ctrl_value;
    logic        r_bend_valid;
    logic [13:0] r_bend_value;
    logic [3:0]  r_event_channel;

    logic        w_accept;
    logic [7:0]  w_byte;
    logic        w_is_data;
    logic        w_is_realtime;
    logic        w_is_system;
    logic        w_new_two_data;
    logic        w_rs_one_data;
    logic        w_ch_ok;
    logic [3:0]  w_type;

    assign w_byte         = bus.byteInput;
    assign w_accept       = bus.byteInputReady & ~r_ready_prev;
    assign w_is_data      = ~w_byte[7];
    assign w_is_realtime  = (w_byte[7:3] == 5'b11111);
    assign w_is_system    = (w_byte[7:4] == 4'hF) & ~w_is_realtime;
    // Status types whose first data byte is expected straight away (WAIT_D1).
    assign w_new_two_data = (w_byte[7:4] == 4'h8) | (w_byte[7:4] == 4'h9) |
                            (w_byte[7:4] == 4'hB) | (w_byte[7:4] == 4'hE);
    assign w_type         = r_status[7:4];
    assign w_rs_one_data  = (w_type == 4'hC) | (w_type == 4'hD);
    assign w_ch_ok        = !CHANNEL_FILTER_EN || (r_status[3:0] == ChannelNib);

    // Parser FSM with registered event strobes and fields.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_state         <= StIdle;
            r_ready_prev    <= 1'b0;
            r_status        <= 8'h00;
            r_rs_valid      <= 1'b0;
            r_d1            <= 7'h00;
            r_note_valid    <= 1'b0;
            r_note_gate     <= 1'b0;
            r_note_number   <= 7'h00;
            r_note_velocity <= 7'h00;
            r_ctrl_valid    <= 1'b0;
            r_ctrl_number   <= 7'h00;
            r_ctrl_value    <= 7'h00;
            r_bend_valid    <= 1'b0;
            r_bend_value    <= 14'h0000;
            r_event_channel <= 4'h0;
        end else begin
            r_ready_prev <= bus.byteInputReady;
            r_note_valid <= 1'b0;
            r_ctrl_valid <= 1'b0;
            r_bend_valid <= 1'b0;
            if (w_accept) begin
                if (w_is_data) begin
                    unique case (r_state)
                        StIdle: begin
                            // Running status: byte is D1; 0xC/0xD complete here, unused.
                            if (r_rs_valid && !w_rs_one_data) begin
                                r_d1    <= w_byte[6:0];
                                r_state <= StWaitD2;
                            end
                        end
                        StWaitD1: begin
                            r_d1    <= w_byte[6:0];
                            r_state <= StWaitD2;
                        end
                        StWaitD2: begin
                            r_state <= StIdle;
                            if (w_ch_ok) begin
                                case (w_type)
                                    4'h8, 4'h9: begin
                                        r_note_valid    <= 1'b1;
                                        r_note_gate     <= (w_type == 4'h9) &&
                                                           (w_byte[6:0] != 7'h00);
                                        r_note_number   <= r_d1;
                                        r_note_velocity <= w_byte[6:0];
                                        r_event_channel <= r_status[3:0];
                                    end
                                    4'hB: begin
                                        r_ctrl_valid    <= 1'b1;
                                        r_ctrl_number   <= r_d1;
                                        r_ctrl_value    <= w_byte[6:0];
                                        r_event_channel <= r_status[3:0];
                                    end
                                    4'hE: begin
                                        r_bend_valid    <= 1'b1;
                                        r_bend_value    <= {w_byte[6:0], r_d1};
                                        r_event_channel <= r_status[3:0];
                                    end
                                    default: ; // 0xA aftertouch: consumed, discarded
                                endcase
                            end
                        end
                        default: r_state <= StIdle;
                    endcase
                end else if (w_is_system) begin
                    r_rs_valid <= 1'b0;
                    r_status   <= 8'h00;
                    r_state    <= StIdle;
                end else if (!w_is_realtime) begin
                    // Channel status byte: aborts any partial message.
                    r_status   <= w_byte;
                    r_rs_valid <= 1'b1;
                    r_state    <= w_new_two_data ? StWaitD1 : StIdle;
                end
            end
        end
    end

    assign bus.noteValid    = r_note_valid;
    assign bus.noteGate     = r_note_gate;
    assign bus.noteNumber   = r_note_number;
    assign bus.noteVelocity = r_note_velocity;
    assign bus.ctrlValid    = r_ctrl_valid;
    assign bus.ctrlNumber   = r_ctrl_number;
    assign bus.ctrlValue    = r_ctrl_value;
    assign bus.bendValid    = r_bend_valid;
    assign bus.bendValue    = r_bend_value;
    assign bus.eventChannel = r_event_channel;
endmodule
